// File: rtl/uart_loop_checker.sv
// Loopback self-test initiator: streams SEED+k into the tx FIFO, pops the echoes
// from the rx FIFO, and reports mismatches, the first bad byte and inter-byte timeouts.
module uart_loop_checker #(
    parameter int unsigned NUM_BYTES      = 256,
    parameter logic [7:0]  SEED           = 8'h00,
    parameter int unsigned WINDOW         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_full,
    output logic        rx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [7:0]  first_bad
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [15:0]      ERR_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [CNT_W-1:0]  recv_q, recv_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [15:0]       err_d;
    logic [7:0]        first_bad_d;
    logic              busy_d, done_d, pass_d, timeout_d;

    logic [CNT_W-1:0]  in_flight;
    logic              running;
    logic              pop;
    logic [7:0]        rx_expected;

    // FIFO handshakes decoded from registered counters and the FIFO flags
    always_comb begin
        running     = (state_q == ST_RUN);
        in_flight   = sent_q - recv_q;
        tx_en       = running && (sent_q < LAST_CNT) && !tx_full && (in_flight < WIN_CNT);
        tx_data     = SEED + sent_q[7:0];
        rx_en       = !rx_empty;
        pop         = running && !rx_empty;
        rx_expected = SEED + recv_q[7:0];
    end

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sent_q    <= '0;
            recv_q    <= '0;
            tcnt_q    <= '0;
            err_count <= '0;
            first_bad <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            tcnt_q    <= tcnt_d;
            err_count <= err_d;
            first_bad <= first_bad_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            timeout   <= timeout_d;
        end
    end

    // Next-state, counter and result logic
    always_comb begin
        state_d     = state_q;
        sent_d      = sent_q;
        recv_d      = recv_q;
        tcnt_d      = tcnt_q;
        err_d       = err_count;
        first_bad_d = first_bad;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        timeout_d   = timeout;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    sent_d      = '0;
                    recv_d      = '0;
                    tcnt_d      = '0;
                    err_d       = '0;
                    first_bad_d = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (tx_en) begin
                    sent_d = sent_q + CNT_W'(1);
                end
                if (pop) begin
                    recv_d = recv_q + CNT_W'(1);
                    tcnt_d = '0;
                    if (rx_data != rx_expected) begin
                        if (err_count != ERR_MAX) begin
                            err_d = err_count + 16'd1;
                        end
                        if (err_count == 16'd0) begin
                            first_bad_d = rx_data;
                        end
                    end
                    // The last pop ends the run; a pop always clears the idle count
                    if (recv_d == LAST_CNT) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 16'd0);
                    end
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                    if (tcnt_d == TO_LIMIT) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_loop_checker.sv
// Bench for uart_loop_checker: a queue-based tx->rx loopback with optional
// corruption, drops, back-pressure and rx stalls, plus a byte-sequence scoreboard.
module tb_uart_loop_checker;

    localparam int          NB     = 16;
    localparam logic [7:0]  SEED   = 8'hF8;
    localparam int          WINDOW = 4;
    localparam int          TO     = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_full = 1'b0;
    logic        rx_en;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [7:0]  first_bad;

    uart_loop_checker #(
        .NUM_BYTES(NB), .SEED(SEED), .WINDOW(WINDOW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .tx_en(tx_en), .tx_data(tx_data), .tx_full(tx_full),
        .rx_en(rx_en), .rx_data(rx_data), .rx_empty(rx_empty),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_bad(first_bad)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Loopback environment state
    logic [7:0]  rxq[$];
    logic [7:0]  rx_log[$];
    int          push_cnt = 0;
    int          pop_cnt = 0;
    int unsigned full_pct = 0;
    int unsigned stall_pct = 0;
    bit          drop_all = 0;
    bit          force_full = 0;
    bit          sb_on = 0;
    logic [15:0] corrupt_mask = '0;
    logic        pend_push, pend_pop;
    logic [7:0]  pend_data;

    // Drive FIFO flags on the falling edge, sample handshakes, act on the rising edge
    always begin
        @(negedge clk);
        tx_full  = force_full || ($urandom_range(99) < full_pct);
        rx_empty = (rxq.size() == 0) || ($urandom_range(99) < stall_pct);
        rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        #1;
        pend_push = tx_en;
        pend_data = tx_data;
        pend_pop  = rx_en;
        @(posedge clk);
        if (pend_push && sb_on) begin
            chk("in_flight_limit", 32'((push_cnt - pop_cnt) < WINDOW), 32'd1);
            chk("tx_seq", 32'(pend_data), 32'(8'(SEED + 8'(push_cnt))));
            chk("push_count_limit", 32'(push_cnt < NB), 32'd1);
        end
        if (pend_pop && rxq.size() != 0) begin
            logic [7:0] b;
            b = rxq.pop_front();
            if (sb_on) begin
                pop_cnt++;
                rx_log.push_back(b);
            end
        end
        if (pend_push) begin
            logic [7:0] b;
            b = pend_data;
            if (push_cnt < NB && corrupt_mask[push_cnt[3:0]]) b = b ^ 8'h01;
            if (!drop_all) rxq.push_back(b);
            if (sb_on) push_cnt++;
        end
    end

    typedef struct {
        logic [15:0] mask;
        int unsigned full_pct;
        int unsigned stall_pct;
        bit          drop;
        bit          exp_pass;
        bit          exp_to;
        logic [15:0] exp_err;
        logic [7:0]  exp_fb;
    } vec_t;

    vec_t tbl[6];

    task automatic begin_run();
        push_cnt = 0;
        pop_cnt  = 0;
        rx_log.delete();
        sb_on = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
    endtask

    // Wait for the last pop or done; done must be visible right after the last pop
    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || pop_cnt >= NB) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("run_end_within_budget", 32'd0, 32'd1);
        chk("done_at_end", 32'(done), 32'd1);
        chk("busy_at_end", 32'(busy), 32'd0);
    endtask

    // Reference: count mismatches of the popped stream against SEED+k
    task automatic model_check();
        int          errs;
        logic [7:0]  fb;
        errs = 0;
        fb   = 8'h00;
        foreach (rx_log[i]) begin
            if (rx_log[i] != 8'(SEED + 8'(i))) begin
                if (errs == 0) fb = rx_log[i];
                errs++;
            end
        end
        chk("model_err_count", 32'(err_count), 32'(errs));
        chk("model_first_bad", 32'(first_bad), 32'(fb));
        chk("model_pass", 32'(pass), 32'(errs == 0 && pop_cnt == NB));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
        chk({tag, "_first_bad"}, 32'(first_bad), 32'd0);
        chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'(SEED));
        chk({tag, "_rx_en"}, 32'(rx_en), 32'(!rx_empty));
    endtask

    initial begin
        int n;

        //           mask      full stall drop pass  to  err    fb
        tbl[0] = '{16'h0000,   0,   0,   0,   1,   0, 16'd0, 8'h00};
        tbl[1] = '{16'h0008,   0,   0,   0,   0,   0, 16'd1, 8'hFA};
        tbl[2] = '{16'h8001,   0,  20,   0,   0,   0, 16'd2, 8'hF9};
        tbl[3] = '{16'h0000,  30,  30,   0,   1,   0, 16'd0, 8'h00};
        tbl[4] = '{16'h0400,  25,  25,   0,   0,   0, 16'd1, 8'h03};
        tbl[5] = '{16'h0000,   0,   0,   1,   0,   1, 16'd0, 8'h00};

        reset = 1'b0;
        start = 1'b0;
        #22;
        check_reset_values("por");
        @(posedge clk);
        #3 reset = 1'b1;

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            corrupt_mask = tbl[v].mask;
            full_pct     = tbl[v].full_pct;
            stall_pct    = tbl[v].stall_pct;
            drop_all     = tbl[v].drop;
            begin_run();
            wait_end(3000);
            chk($sformatf("v%0d_pass", v), 32'(pass), 32'(tbl[v].exp_pass));
            chk($sformatf("v%0d_timeout", v), 32'(timeout), 32'(tbl[v].exp_to));
            chk($sformatf("v%0d_err", v), 32'(err_count), 32'(tbl[v].exp_err));
            chk($sformatf("v%0d_first_bad", v), 32'(first_bad), 32'(tbl[v].exp_fb));
            if (tbl[v].drop) begin
                chk($sformatf("v%0d_pushes", v), 32'(push_cnt), 32'(WINDOW));
            end else begin
                chk($sformatf("v%0d_pushes", v), 32'(push_cnt), 32'(NB));
                model_check();
            end
            sb_on = 0;
            full_pct = 0;
            stall_pct = 0;
            drop_all = 0;
            corrupt_mask = '0;
            repeat (4) @(negedge clk);
        end

        // Timeout lands exactly TO cycles after the start edge when nothing echoes
        drop_all = 1;
        push_cnt = 0;
        pop_cnt  = 0;
        sb_on = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle_count", 32'(n), 32'(TO));
        chk("timeout_flag", 32'(timeout), 32'd1);
        chk("timeout_pass", 32'(pass), 32'd0);
        chk("timeout_pushes", 32'(push_cnt), 32'(WINDOW));
        sb_on = 0;
        drop_all = 0;
        repeat (2) @(negedge clk);

        // Back-pressure: tx_full held for 50 cycles mid-run
        begin_run();
        n = 0;
        while (push_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        force_full = 1;
        repeat (50) begin
            @(negedge clk);
            #2;
            chk("tx_en_while_full", 32'(tx_en), 32'd0);
        end
        force_full = 0;
        wait_end(1000);
        chk("full_hold_pass", 32'(pass), 32'd1);
        chk("full_hold_pushes", 32'(push_cnt), 32'(NB));
        model_check();
        sb_on = 0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-run, stale echoes drained, then a clean rerun
        begin_run();
        n = 0;
        while (push_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb_on = 0;
        #1;
        check_reset_values("mid_reset");
        repeat (3) @(negedge clk);
        chk("in_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        n = 0;
        while (rxq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("stale_drained", 32'(rxq.size()), 32'd0);
        chk("stale_err_count", 32'(err_count), 32'd0);
        chk("stale_done", 32'(done), 32'd0);
        chk("stale_tx_data", 32'(tx_data), 32'(SEED));
        begin_run();
        wait_end(1000);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_err", 32'(err_count), 32'd0);
        model_check();
        sb_on = 0;

        // start while running is ignored: a second pulse mid-run must not restart
        begin_run();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(1000);
        chk("start_in_run_pushes", 32'(push_cnt), 32'(NB));
        chk("start_in_run_pass", 32'(pass), 32'd1);
        sb_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
